lsu_dmem_if: RTL
================

# lsu_dmem_if

Load/store unit sitting directly downstream of the instruction controller in the RV32I datapath. Consumes the controller's memory-access decode (MemRead, MemWrite, WBSel, LoadStore_Sel) plus the ALU address and rs2 data. Drives a req/ready data-memory port with byte enables, stalls the pipeline until the access completes, and returns a sign/zero-extended load result for the writeback mux.

## Interface
Parameters:
- AW, 32, byte-address width
- DW, 32, data width (fixed 32; other values unsupported)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- MemRead  in  1  load request from controller
- MemWrite  in  1  store request from controller
- WBSel  in  2  writeback select; a load is started only when WBSel==2'b00
- LoadStore_Sel  in  3  000 byte, 001 half, 010 word, 011 byte-unsigned, 100 half-unsigned
- addr  in  AW  ALU result (effective address)
- wdata  in  DW  store data (rs2)
- rdata  out  DW  extended load result, registered
- rdata_valid  out  1  one-cycle pulse when rdata is updated
- stall  out  1  freeze PC and pipeline registers
- misalign_err  out  1  one-cycle pulse on misaligned access (macro only; else tied 0)
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  DW  lane-replicated store data
- dmem_ready  in  1  memory accepts/completes request this cycle
- dmem_rdata  in  DW  read word, valid when dmem_ready && !dmem_we

## Operation
- States: IDLE, WAIT, DONE.
- start = (MemRead && WBSel==2'b00) || MemWrite. MemRead with other WBSel (branch/jalr decode) is ignored.
- MemRead and MemWrite both high: treated as store.
- IDLE: on start, latch addr, wdata, LoadStore_Sel, we -> WAIT. Else stay.
- WAIT: dmem_req=1 with latched fields held stable; on dmem_ready -> DONE. Loads capture extracted dmem_rdata into rdata.
- DONE: rdata_valid=1 for loads; inputs ignored (instruction is retiring) -> IDLE.
- stall = (IDLE && start) || WAIT; combinational, 0 in DONE.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111. Store LoadStore_Sel values 011/100 and undefined values are treated as word.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extraction: lane = dmem_rdata >> (8*addr[1:0]) (half uses addr[1]); sign-extend for 000/001, zero-extend for 011/100; word unchanged.
- Reset values: state IDLE, rdata 0, rdata_valid 0, dmem_req 0, dmem_we 0, dmem_be 0, dmem_addr 0, dmem_wdata 0, misalign_err 0.

## Timing
- Minimum access: start cycle (stall=1), WAIT cycle with dmem_ready=1, DONE cycle -> 2 stall cycles, rdata valid in DONE.
- Each extra cycle dmem_ready=0 adds one stall cycle; no timeout.
- dmem_req never drops before dmem_ready; fields never change while dmem_req=1.
- Back-to-back accesses: next instruction sampled in IDLE the cycle after DONE.
- Reset mid-access: dmem_req drops immediately (async), request abandoned, no rdata_valid.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no memory request; IDLE -> DONE directly, misalign_err pulses in DONE, rdata unchanged, rdata_valid=0; stall for one cycle.
- Undefined: low address bits below access size ignored (half uses addr[1], word uses none); access proceeds normally; misalign_err tied 0.

## Structure
- Shared package riscv_pkg: LoadStore_Sel encodings (LS_B, LS_H, LS_W, LS_BU, LS_HU), LSU state enum.
- One sub-module: lsu_align (combinational byte-enable generation, store lane replication, load extraction/extension); FSM and registers in lsu_dmem_if.

## Test plan
- Load byte signed, addr 0x103, dmem_rdata 0x80FF_1234, ready on first WAIT cycle -> dmem_be 4'b1000, dmem_addr 0x100, rdata 0xFFFF_FF80, stall 2 cycles.
- Load half unsigned, addr 0x202, rdata 0xBEEF_0000, dmem_ready delayed 3 cycles -> rdata 0x0000_BEEF, stall 5 cycles, req fields stable throughout.
- Store byte, addr 0x001, wdata 0x1234_56AB -> dmem_we 1, dmem_be 4'b0010, dmem_wdata 0xABAB_ABAB, no rdata_valid.
- MemRead=1, WBSel=2'b10 (branch) -> no dmem_req, stall 0.
- rst_n low during WAIT -> dmem_req 0 same cycle, state IDLE, no rdata_valid after release.
- With LSU_MISALIGN_TRAP_EN, load word at 0x102 -> no dmem_req, misalign_err pulse, stall 1 cycle; without macro -> access 0x100 with be 4'b1111.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I load/store encodings, LSU state enum and access-size helpers
package riscv_pkg;
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b011;
  localparam logic [2:0] LS_HU = 3'b100;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} lsu_state_e;
  // Stores have no unsigned forms, so BU/HU (and undefined codes) fall back to word
  function automatic logic [1:0] ls_size(input logic [2:0] sel, input logic we);
    logic b, h;
    b = sel == LS_B || (!we && sel == LS_BU);
    h = sel == LS_H || (!we && sel == LS_HU);
    return b ? SZ_B : h ? SZ_H : SZ_W;
  endfunction
  function automatic logic ls_misaligned(input logic [2:0] sel, input logic we, input logic [1:0] lo);
    logic [1:0] sz;
    sz = ls_size(sel, we);
    return (sz == SZ_H && lo[0]) || (sz == SZ_W && lo != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-enable generation, store lane replication, load lane extraction/extension
//   sel_i   LoadStore_Sel of the access    we_i   1 = store
//   lo_i    addr[1:0]                      wdata_i/wdata_o  raw / replicated store data
//   rdata_i memory word                    rdata_o extended load result   be_o byte enables
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  sel_i,
  input  logic        we_i,
  input  logic [1:0]  lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  logic [1:0] sz;
  logic [31:0] sh_b, sh_h;
  logic sx;
  always_comb begin
    sz = ls_size(sel_i, we_i);
    sh_b = rdata_i >> {lo_i, 3'b000};
    sh_h = rdata_i >> {lo_i[1], 4'b0000};
    sx = sel_i == LS_B || sel_i == LS_H;
    be_o = sz == SZ_B ? 4'b0001 << lo_i : sz == SZ_H ? 4'b0011 << {lo_i[1], 1'b0} : 4'b1111;
    wdata_o = sz == SZ_B ? {4{wdata_i[7:0]}} : sz == SZ_H ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_o = sz == SZ_B ? {{24{sx & sh_b[7]}}, sh_b[7:0]} :
              sz == SZ_H ? {{16{sx & sh_h[15]}}, sh_h[15:0]} : rdata_i;
  end
endmodule

// File: rtl/lsu_dmem_if.sv
// lsu_dmem_if: RV32I load/store unit driving a req/ready data-memory port with pipeline stall
//   controller side: MemRead, MemWrite, WBSel, LoadStore_Sel, addr, wdata -> rdata, rdata_valid, stall, misalign_err
//   memory side:     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata <- dmem_ready, dmem_rdata
//   LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip memory and pulse misalign_err
module lsu_dmem_if
  import riscv_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          MemRead,
  input  logic          MemWrite,
  input  logic [1:0]    WBSel,
  input  logic [2:0]    LoadStore_Sel,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          stall,
  output logic          misalign_err,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [3:0]    dmem_be,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ready,
  input  logic [DW-1:0] dmem_rdata
);
  lsu_state_e state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic [2:0] sel_q;
  logic we_q, rdata_valid_q, misalign_q;
  logic start, take, mis, fill;
  logic [3:0] be;
  logic [DW-1:0] wrep, ext;
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = ls_misaligned(LoadStore_Sel, MemWrite, addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  // MemRead with non-memory WBSel is a branch/jalr decode, not a load
  always_comb begin
    start = (MemRead && WBSel == 2'b00) || MemWrite;
    take = state_q == ST_IDLE && start;
    fill = state_q == ST_WAIT && dmem_ready && !we_q;
    state_d = take ? (mis ? ST_DONE : ST_WAIT) :
              state_q == ST_WAIT ? (dmem_ready ? ST_DONE : ST_WAIT) : ST_IDLE;
  end
  lsu_align u_align (
    .sel_i  (sel_q),
    .we_i   (we_q),
    .lo_i   (addr_q[1:0]),
    .wdata_i(wdata_q),
    .rdata_i(dmem_rdata),
    .be_o   (be),
    .wdata_o(wrep),
    .rdata_o(ext)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      sel_q         <= LS_B;
      we_q          <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        sel_q   <= LoadStore_Sel;
        we_q    <= MemWrite;
      end
      if (fill) rdata_q <= ext;
      rdata_valid_q <= fill;
      misalign_q    <= take && mis;
    end
  // Request is a pure decode of the state register so async reset drops it at once
  assign dmem_req     = state_q == ST_WAIT;
  assign dmem_we      = we_q;
  assign dmem_addr    = {addr_q[AW-1:2], 2'b00};
  assign dmem_be      = dmem_req ? be : 4'b0000;
  assign dmem_wdata   = wrep;
  assign stall        = take || dmem_req;
  assign rdata        = rdata_q;
  assign rdata_valid  = rdata_valid_q;
  assign misalign_err = misalign_q;
endmodule
